fnd_scan_decoder: RTL and testbench

// - Monitor/receiver for the 4-digit multiplexed 7-segment (FND) scan bus driven by the FND controller.
// - Samples font/digit lines, decodes each segment pattern back to BCD and reassembles the displayed value 0..9999.
// - Reports each complete scan frame with a one-cycle pulse.
// - Used for in-system self-check of the display path and as the checker in display testbenches.

---
 rtl/fnd_scan_decoder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: receiver for a 4-digit multiplexed active-low 7-segment
// scan bus. Each settled digit pattern is decoded back to BCD, the four digits
// are reassembled into a 0..9999 value and every complete frame is reported.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_font[7:0]         segments, active-low, [7]=dp, [6:0]=g..a
//   i_digit[3:0]        digit select, active-low one-hot (1110 = ones)
//   o_value[13:0]       last good frame value
//   o_valid             pulse: good frame, o_value/o_blank updated
//   o_blank             level: last good frame was fully blank
//   o_error             pulse: frame completed with an undecodable pattern
//   o_timeout           pulse: no frame completed within FRAME_TIMEOUT cycles
//   o_dp[3:0]           (FND_SCAN_DP_EN only) decimal points, bit0 = ones
//
// Build option: define FND_SCAN_DP_EN to add o_dp and honour i_font[7].

module fnd_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_font,
    input  logic [3:0]  i_digit,
    output logic [13:0] o_value,
    output logic        o_valid,
    output logic        o_blank,
    output logic        o_error,
    output logic        o_timeout
`ifdef FND_SCAN_DP_EN
    ,
    output logic [3:0]  o_dp
`endif
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     bus_now;
    logic [11:0]     bus_q;
    logic [SW-1:0]   stab_q, stab_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0][3:0] slot_q, slot_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      blank_q, blank_d;
    logic            bad_q, bad_d;
    logic [13:0]     value_q, value_d;
    logic            valid_q, valid_d;
    logic            oblank_q, oblank_d;
    logic            error_q, error_d;
    logic            tmo_out_q, tmo_out_d;

    logic            sel_ok;
    logic [1:0]      sel_idx;
    logic [3:0]      dec_bcd;
    logic            dec_blank;
    logic            dec_bad;
    logic            capture;
    logic            take;
    logic            frame_done;
    logic            tmo_hit;
    logic [3:0]      d_o, d_t, d_h, d_th;
    logic [13:0]     sum;

`ifdef FND_SCAN_DP_EN
    logic [3:0]      dp_slot_q, dp_slot_d;
    logic [3:0]      dp_q, dp_d;

    assign bus_now = {i_digit, i_font};
`else
    logic            unused_font7;

    // The dp line is not part of the decoded state in this build, so a
    // toggling dp must not even restart the settle window.
    assign bus_now      = {i_digit, 1'b0, i_font[6:0]};
    assign unused_font7 = i_font[7];
`endif

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (i_digit)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dec_bcd   = 4'd0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (i_font[6:0])
            7'h40:   dec_bcd   = 4'd0;
            7'h79:   dec_bcd   = 4'd1;
            7'h24:   dec_bcd   = 4'd2;
            7'h30:   dec_bcd   = 4'd3;
            7'h19:   dec_bcd   = 4'd4;
            7'h12:   dec_bcd   = 4'd5;
            7'h02:   dec_bcd   = 4'd6;
            7'h78:   dec_bcd   = 4'd7;
            7'h00:   dec_bcd   = 4'd8;
            7'h10:   dec_bcd   = 4'd9;
            7'h7F:   dec_blank = 1'b1;
            default: dec_bad   = 1'b1;
        endcase
    end

    // Settle counter: restarts on any bus change, parks at SETTLE_MAX.
    always_comb begin
        stab_d = stab_q;
        if (!sel_ok || (bus_now != bus_q)) begin
            stab_d = '0;
        end else if (stab_q != SETTLE_MAX) begin
            stab_d = stab_q + 1'b1;
        end
    end

    // One capture per dwell: only on the transition into saturation.
    assign capture = (stab_d == SETTLE_MAX) && (stab_q != SETTLE_MAX);

    assign frame_done = (state_q == ST_FILL) && (mask_q == 4'hF);

    // A completing frame takes priority over an expiring timeout.
    assign tmo_hit = (state_q != ST_DONE) && (tmo_q == TMO_LAST) && !frame_done;

    assign take = capture && !tmo_hit &&
                  ((state_q != ST_SYNC) || (sel_idx == 2'd0));

    assign d_o  = blank_q[0] ? 4'd0 : slot_q[0];
    assign d_t  = blank_q[1] ? 4'd0 : slot_q[1];
    assign d_h  = blank_q[2] ? 4'd0 : slot_q[2];
    assign d_th = blank_q[3] ? 4'd0 : slot_q[3];

    assign sum = 14'(d_th) * 14'd1000 + 14'(d_h) * 14'd100 +
                 14'(d_t) * 14'd10 + 14'(d_o);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        slot_d    = slot_q;
        blank_d   = blank_q;
        bad_d     = bad_q;
        tmo_d     = tmo_q + 1'b1;
        value_d   = value_q;
        oblank_d  = oblank_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        tmo_out_d = 1'b0;
`ifdef FND_SCAN_DP_EN
        dp_slot_d = dp_slot_q;
        dp_d      = dp_q;
`endif

        unique case (state_q)
            ST_SYNC: if (take) state_d = ST_FILL;
            ST_FILL: if (frame_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_FILL;
            default: state_d = ST_SYNC;
        endcase

        if ((state_q == ST_DONE) || tmo_hit) begin
            tmo_d   = '0;
            mask_d  = 4'h0;
            blank_d = 4'h0;
            bad_d   = 1'b0;
        end

        if (tmo_hit) begin
            state_d   = ST_SYNC;
            tmo_out_d = 1'b1;
        end

        // Applied after the frame clear so a capture landing in DONE
        // already belongs to the next frame.
        if (take) begin
            slot_d[sel_idx]  = dec_bcd;
            mask_d[sel_idx]  = 1'b1;
            blank_d[sel_idx] = dec_blank;
            bad_d            = bad_d | dec_bad;
`ifdef FND_SCAN_DP_EN
            dp_slot_d[sel_idx] = ~i_font[7];
`endif
        end

        if (frame_done) begin
            if (bad_q) begin
                error_d = 1'b1;
            end else begin
                valid_d  = 1'b1;
                oblank_d = &blank_q;
                if (!(&blank_q)) begin
                    value_d = sum;
                end
`ifdef FND_SCAN_DP_EN
                dp_d = dp_slot_q;
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_SYNC;
            bus_q     <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            slot_q    <= '0;
            mask_q    <= 4'h0;
            blank_q   <= 4'h0;
            bad_q     <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            oblank_q  <= 1'b0;
            error_q   <= 1'b0;
            tmo_out_q <= 1'b0;
`ifdef FND_SCAN_DP_EN
            dp_slot_q <= 4'h0;
            dp_q      <= 4'h0;
`endif
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_now;
            stab_q    <= stab_d;
            tmo_q     <= tmo_d;
            slot_q    <= slot_d;
            mask_q    <= mask_d;
            blank_q   <= blank_d;
            bad_q     <= bad_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            oblank_q  <= oblank_d;
            error_q   <= error_d;
            tmo_out_q <= tmo_out_d;
`ifdef FND_SCAN_DP_EN
            dp_slot_q <= dp_slot_d;
            dp_q      <= dp_d;
`endif
        end
    end

    assign o_value   = value_q;
    assign o_valid   = valid_q;
    assign o_blank   = oblank_q;
    assign o_error   = error_q;
    assign o_timeout = tmo_out_q;
`ifdef FND_SCAN_DP_EN
    assign o_dp      = dp_q;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: directed scan frames, a frame-level reference
// model compared every cycle, plus hand-computed literal expectations.

module tb_fnd_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 1000;
    localparam int DWELL  = 50;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  font  = 8'hFF;
    logic [3:0]  digit = 4'hF;
    logic [13:0] value;
    logic        valid, blank, err, timeout;
`ifdef FND_SCAN_DP_EN
    logic [3:0]  dp;
`endif

    fnd_scan_decoder #(
        .SETTLE_CYCLES(SETTLE),
        .FRAME_TIMEOUT(TMO)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_font   (font),
        .i_digit  (digit),
        .o_value  (value),
        .o_valid  (valid),
        .o_blank  (blank),
        .o_error  (err),
        .o_timeout(timeout)
`ifdef FND_SCAN_DP_EN
        ,
        .o_dp     (dp)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pw [4] = '{1, 10, 100, 1000};

    function automatic logic [7:0] seg(input int d);
        return {1'b1, seg_tab[d]};
    endfunction

    function automatic int dig(input int v, input int i);
        return (v / pw[i]) % 10;
    endfunction

    function automatic logic [3:0] dsel(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return 4'hF ^ (one << i);
    endfunction

    function automatic int decode(input logic [6:0] p);
        if (p == 7'h7F) return 10;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    function automatic int slot_of(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (d == dsel(i)) return i;
        return -1;
    endfunction

    // ---------------- reference model (frame level) ----------------
    logic [11:0] m_prev;
    bit          m_prev_ok;
    int          m_run, m_age;
    int          m_slot [4];
    bit          m_have [4];
    bit          m_bad, m_sync, m_emit, m_done;
    int          e_value;
    bit          e_valid, e_blank, e_error, e_tmo;
`ifdef FND_SCAN_DP_EN
    bit          m_dpb [4];
    logic [3:0]  e_dp;
`endif

    always @(posedge clk) begin
        logic [11:0] cur;
        int d, sum;
        bit cap, allb, full;
`ifdef FND_SCAN_DP_EN
        cur = {digit, font};
`else
        cur = {digit, 1'b0, font[6:0]};
`endif
        e_valid = 0;
        e_error = 0;
        e_tmo   = 0;
        if (rst) begin
            m_prev_ok = 0; m_run = 0; m_age = 0;
            m_bad = 0; m_sync = 0; m_emit = 0; m_done = 0;
            for (int i = 0; i < 4; i++) begin
                m_have[i] = 0; m_slot[i] = 0;
`ifdef FND_SCAN_DP_EN
                m_dpb[i] = 0;
`endif
            end
            e_value = 0; e_blank = 0;
`ifdef FND_SCAN_DP_EN
            e_dp = 4'h0;
`endif
        end else begin
            if (m_prev_ok && cur == m_prev) m_run++;
            else m_run = 0;
            m_prev    = cur;
            m_prev_ok = 1;
            d   = slot_of(digit);
            cap = (d >= 0) && (m_run == SETTLE);
            if (m_emit) begin
                m_emit = 0; m_done = 1; cap = 0;
                allb = 1; sum = 0;
                for (int i = 0; i < 4; i++)
                    if (m_slot[i] != 10) begin
                        allb = 0;
                        sum += m_slot[i] * pw[i];
                    end
                if (m_bad) e_error = 1;
                else begin
                    e_valid = 1;
                    e_blank = allb;
                    if (!allb) e_value = sum;
`ifdef FND_SCAN_DP_EN
                    for (int i = 0; i < 4; i++) e_dp[i] = m_dpb[i];
`endif
                end
                for (int i = 0; i < 4; i++) m_have[i] = 0;
                m_bad = 0;
            end else if (m_done) begin
                m_done = 0;
                m_age  = 0;
            end else begin
                m_age++;
                if (m_age == TMO) begin
                    e_tmo = 1; m_age = 0; m_sync = 0; cap = 0;
                    for (int i = 0; i < 4; i++) m_have[i] = 0;
                    m_bad = 0;
                end
            end
            if (cap && (m_sync || d == 0)) begin
                m_sync    = 1;
                m_slot[d] = decode(font[6:0]);
                m_have[d] = 1;
`ifdef FND_SCAN_DP_EN
                m_dpb[d]  = ~font[7];
`endif
                if (m_slot[d] < 0) m_bad = 1;
                full = 1;
                for (int i = 0; i < 4; i++) if (!m_have[i]) full = 0;
                if (full) m_emit = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            n_cmp++;
            if (value !== e_value[13:0] || valid !== e_valid ||
                blank !== e_blank || err !== e_error || timeout !== e_tmo) begin
                n_bad++;
                $display("FAIL model cyc=%0d got val=%0d v=%b b=%b e=%b t=%b want val=%0d v=%b b=%b e=%b t=%b",
                         cyc, value, valid, blank, err, timeout,
                         e_value, e_valid, e_blank, e_error, e_tmo);
            end
`ifdef FND_SCAN_DP_EN
            n_cmp++;
            if (dp !== e_dp) begin
                n_bad++;
                $display("FAIL model_dp cyc=%0d got=%b want=%b", cyc, dp, e_dp);
            end
`endif
        end
    end

    // ---------------- event recorder ----------------
    int n_valid = 0, n_err = 0, n_tmo = 0;
    int last_val = -1, valid_cyc = -1, tmo_cyc = -1;
    bit last_blank = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid++;
            last_val   = int'(value);
            last_blank = blank;
            valid_cyc  = cyc;
        end
        if (err === 1'b1) n_err++;
        if (timeout === 1'b1) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic put(input logic [3:0] dg, input logic [7:0] f,
                       input int n, output int st);
        @(posedge clk);
        #1;
        digit = dg;
        font  = f;
        st    = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic frame4(input logic [7:0] f0, input logic [7:0] f1,
                          input logic [7:0] f2, input logic [7:0] f3,
                          output int st3);
        int st;
        put(dsel(0), f0, DWELL, st);
        put(dsel(1), f1, DWELL, st);
        put(dsel(2), f2, DWELL, st);
        put(dsel(3), f3, DWELL, st3);
    endtask

    task automatic frame(input int v, output int st3);
        frame4(seg(dig(v, 0)), seg(dig(v, 1)), seg(dig(v, 2)),
               seg(dig(v, 3)), st3);
    endtask

    int rel;

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        digit = 4'hF;
        font  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
    endtask

    initial begin
        int st, v0, e0, t0;

        do_reset();
        chk("reset_value", int'(value), 0);
        chk("reset_flags", int'({valid, blank, err, timeout}), 0);

        frame(1234, st);
        chk("first_latency", valid_cyc - st, SETTLE + 2);
        chk("first_value", last_val, 1234);
        chk("first_blank", int'(last_blank), 0);
        frame(1234, st);
        frame(1234, st);
        chk("valid_per_frame", n_valid, 3);

        frame(9999, st);
        chk("value_9999", last_val, 9999);
        frame(0, st);
        chk("value_0000", last_val, 0);
        chk("no_error", n_err, 0);

        frame(1234, st);
        frame4(8'hFF, 8'hFF, 8'hFF, 8'hFF, st);
        chk("blank_flag", int'(last_blank), 1);
        chk("blank_keeps_value", last_val, 1234);

        v0 = n_valid;
        e0 = n_err;
        frame4(seg(8), 8'hAA, seg(6), seg(5), st);
        chk("bad_error", n_err, e0 + 1);
        chk("bad_no_valid", n_valid, v0);
        chk("bad_value_held", int'(value), 1234);
        frame(5678, st);
        chk("after_bad_value", last_val, 5678);
        chk("after_bad_blank", int'(blank), 0);

        e0 = n_err;
        put(dsel(0), seg(1), DWELL, st);
        put(dsel(1), 8'hAA, 2, st);
        put(dsel(1), seg(2), DWELL - 2, st);
        put(dsel(2), seg(3), DWELL, st);
        put(dsel(3), seg(4), DWELL, st);
        chk("glitch_value", last_val, 4321);
        chk("glitch_no_error", n_err, e0);

        do_reset();
        v0 = n_valid;
        t0 = n_tmo;
        repeat (1100) @(posedge clk);
        chk("timeout_count", n_tmo, t0 + 1);
        chk("timeout_cycle", tmo_cyc - rel, TMO);
        chk("timeout_no_valid", n_valid, v0);
        put(dsel(1), seg(6), DWELL, st);
        put(dsel(2), seg(4), DWELL, st);
        put(dsel(3), seg(2), DWELL, st);
        put(dsel(0), seg(8), DWELL, st);
        put(dsel(1), seg(6), DWELL, st);
        put(dsel(2), seg(4), DWELL, st);
        put(dsel(3), seg(2), DWELL, st);
        chk("resync_count", n_valid, v0 + 1);
        chk("resync_value", last_val, 2468);

        put(dsel(0), seg(3), DWELL, st);
        put(dsel(1), seg(1), DWELL, st);
        do_reset();
        chk("midreset_value", int'(value), 0);
        chk("midreset_flags", int'({valid, blank, err, timeout}), 0);
        v0 = n_valid;
        put(dsel(2), seg(5), DWELL, st);
        put(dsel(3), seg(9), DWELL, st);
        put(dsel(0), seg(7), DWELL, st);
        put(dsel(1), seg(5), DWELL, st);
        put(dsel(2), seg(3), DWELL, st);
        put(dsel(3), seg(1), DWELL, st);
        chk("midreset_count", n_valid, v0 + 1);
        chk("midreset_value2", last_val, 1357);

        frame4(seg(1), seg(2), seg(3) & 8'h7F, seg(4), st);
        chk("dp_frame_value", last_val, 4321);
`ifdef FND_SCAN_DP_EN
        chk("dp_hundreds", int'(dp), 4);
`endif

        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
